// File: rtl/led_disp_pkg.sv
// Shared types and segment encoding for the LED scan counter.
// Segment byte layout {dp,g,f,e,d,c,b,a}, all active-low; dp is never lit.
package led_disp_pkg;

    typedef logic [7:0] seg_code_t;
    typedef logic [3:0] bcd_digit_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

    localparam seg_code_t SEG_0     = 8'hC0;
    localparam seg_code_t SEG_1     = 8'hF9;
    localparam seg_code_t SEG_2     = 8'hA4;
    localparam seg_code_t SEG_3     = 8'hB0;
    localparam seg_code_t SEG_4     = 8'h99;
    localparam seg_code_t SEG_5     = 8'h92;
    localparam seg_code_t SEG_6     = 8'h82;
    localparam seg_code_t SEG_7     = 8'hF8;
    localparam seg_code_t SEG_8     = 8'h80;
    localparam seg_code_t SEG_9     = 8'h90;
    localparam seg_code_t SEG_BLANK = 8'hFF;

    // Decimal digit to active-low segment pattern; non-BCD codes show blank.
    function automatic seg_code_t bcd_to_seg(input bcd_digit_t d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/led_scan_counter_ctrl_if.sv
// Board-side signal bundle of the LED scan counter.
//   button, counter : asynchronous inputs toward the controller
//   led_en          : active-low digit enables
//   led_cx          : active-low segments {dp,g,f,e,d,c,b,a}
//   overflow        : sticky count-wrap flag
interface led_scan_counter_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 8
);
    logic                  button;
    logic                  counter;
    logic [NUM_DIGITS-1:0] led_en;
    logic [7:0]            led_cx;
    logic                  overflow;

    modport master (output button, output counter,
                    input  led_en, input  led_cx, input overflow);
    modport slave  (input  button, input  counter,
                    output led_en, output led_cx, output overflow);
endinterface

// File: rtl/led_scan_counter_ctrl_bcd_counter_chain.sv
// NUM_DIGITS-wide BCD counter with ripple carry; digit 0 is least significant.
//   clk, rst   : clock, async active-low reset
//   i_inc      : increment by one this cycle
//   o_digits   : registered digit vector
//   o_wrap_c   : combinational, high when i_inc rolls all-9s over to all-0s
module bcd_counter_chain
    import led_disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_inc,
    output bcd_digit_t [NUM_DIGITS-1:0]  o_digits,
    output logic                         o_wrap_c
);

    bcd_digit_t [NUM_DIGITS-1:0] r_digits;
    bcd_digit_t [NUM_DIGITS-1:0] w_digits_next;
    logic                        w_carry_out;

    // Carry ripples upward until a digit that is not 9 absorbs it.
    always_comb begin
        logic carry;
        w_digits_next = r_digits;
        carry         = i_inc;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (carry) begin
                if (r_digits[i] == 4'd9) begin
                    w_digits_next[i] = 4'd0;
                end else begin
                    w_digits_next[i] = 4'(r_digits[i] + 4'd1);
                    carry            = 1'b0;
                end
            end
        end
        w_carry_out = carry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_digits <= '0;
        end else begin
            r_digits <= w_digits_next;
        end
    end

    assign o_digits = r_digits;
    assign o_wrap_c = w_carry_out;

endmodule

// File: rtl/led_scan_counter_ctrl.sv
// Edge counter shown in decimal on a time-multiplexed 7-segment display.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of led_scan_counter_ctrl_if (button, counter in;
//          led_en, led_cx, overflow out, all outputs registered)
// Optional build macro LED_LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 always shown).
module led_scan_counter_ctrl
    import led_disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    led_scan_counter_ctrl_if.slave  bus
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);

    logic [SYNC_STAGES-1:0]      r_btn_sync;
    logic [SYNC_STAGES-1:0]      r_cnt_sync;
    logic                        r_btn_prev;
    logic                        r_cnt_prev;
    logic                        w_btn_edge;
    logic                        w_cnt_edge;

    run_state_t                  r_state;
    run_state_t                  w_state_next;
    logic                        w_inc;

    bcd_digit_t [NUM_DIGITS-1:0] w_digits;
    logic                        w_wrap;
    logic                        r_overflow;

    logic [DIV_W-1:0]            r_div;
    logic [IDX_W-1:0]            r_idx;
    logic [NUM_DIGITS-1:0]       w_blank;
    seg_code_t                   w_seg;
    logic [NUM_DIGITS-1:0]       r_led_en;
    seg_code_t                   r_led_cx;

    // Synchronisers followed by a one-flop rising-edge detector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn_sync <= '0;
            r_cnt_sync <= '0;
            r_btn_prev <= 1'b0;
            r_cnt_prev <= 1'b0;
        end else begin
            r_btn_sync <= {r_btn_sync[SYNC_STAGES-2:0], bus.button};
            r_cnt_sync <= {r_cnt_sync[SYNC_STAGES-2:0], bus.counter};
            r_btn_prev <= r_btn_sync[SYNC_STAGES-1];
            r_cnt_prev <= r_cnt_sync[SYNC_STAGES-1];
        end
    end

    assign w_btn_edge = r_btn_sync[SYNC_STAGES-1] & ~r_btn_prev;
    assign w_cnt_edge = r_cnt_sync[SYNC_STAGES-1] & ~r_cnt_prev;

    // Run/stop state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Counting is gated by the current (pre-toggle) state, so a coincident
    // button edge never affects the counter edge in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_inc        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_btn_edge) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                w_inc = w_cnt_edge;
                if (w_btn_edge) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    bcd_counter_chain #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_chain (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (w_inc),
        .o_digits (w_digits),
        .o_wrap_c (w_wrap)
    );

    // Sticky overflow; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_wrap) begin
            r_overflow <= 1'b1;
        end
    end

    // Scan divider and digit index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (r_div == DIV_W'(SCAN_DIV - 1)) begin
            r_div <= '0;
            r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : IDX_W'(r_idx + IDX_W'(1));
        end else begin
            r_div <= DIV_W'(r_div + DIV_W'(1));
        end
    end

`ifdef LED_LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every higher digit are zero; digit 0 never is.
    always_comb begin
        logic higher_zero;
        w_blank     = '0;
        higher_zero = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
            higher_zero = higher_zero && (w_digits[i] == 4'd0);
            w_blank[i]  = higher_zero;
        end
    end
`else
    assign w_blank = '0;
`endif

    assign w_seg = w_blank[r_idx] ? SEG_BLANK : bcd_to_seg(w_digits[r_idx]);

    // Registered pin drive for the currently scanned digit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led_en <= '1;
            r_led_cx <= SEG_BLANK;
        end else begin
            r_led_en <= ~(NUM_DIGITS'(1) << r_idx);
            r_led_cx <= w_seg;
        end
    end

    assign bus.led_en   = r_led_en;
    assign bus.led_cx   = r_led_cx;
    assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_led_scan_counter_ctrl.sv
// Bench for led_scan_counter_ctrl: an 8-digit and a 2-digit instance share
// the same button/counter stimulus; a decimal reference model predicts both.
module tb_led_scan_counter_ctrl;

    localparam int unsigned SCAN = 4;
    localparam int unsigned WIN  = 8 * SCAN + 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic b_in = 1'b0;
    logic c_in = 1'b0;

    always #5 clk = ~clk;

    led_scan_counter_ctrl_if #(.NUM_DIGITS(8)) bus8 ();
    led_scan_counter_ctrl_if #(.NUM_DIGITS(2)) bus2 ();

    assign bus8.button  = b_in;
    assign bus8.counter = c_in;
    assign bus2.button  = b_in;
    assign bus2.counter = c_in;

    led_scan_counter_ctrl #(.NUM_DIGITS(8), .SCAN_DIV(SCAN), .SYNC_STAGES(2)) dut8 (
        .clk (clk), .rst (rst), .bus (bus8));
    led_scan_counter_ctrl #(.NUM_DIGITS(2), .SCAN_DIV(SCAN), .SYNC_STAGES(2)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2));

    typedef struct {
        int unsigned c8;
        int unsigned c2;
        bit          o8;
        bit          o2;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    bit          mon_busy = 1'b0;
    logic [7:0]  seen8;
    logic [1:0]  seen2;
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model: plain decimal counts, run flag and sticky flags.
    int unsigned m_c8 = 0;
    int unsigned m_c2 = 0;
    bit          m_o8 = 1'b0;
    bit          m_o2 = 1'b0;
    bit          m_run = 1'b0;

    logic [7:0]  seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic logic [7:0] exp_seg(input int unsigned v, input int k);
        int unsigned p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
`ifdef LED_LEADING_ZERO_BLANK_EN
        if (k > 0 && (v / p) == 0) return 8'hFF;
`endif
        return seg_tab[(v / p) % 10];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: for each queued expectation, watch a full scan on both DUTs.
    always begin
        @(negedge clk);
        if (sb_q.size() != 0) begin
            mon_e    = sb_q.pop_front();
            mon_busy = 1'b1;
            seen8    = '0;
            seen2    = '0;
            for (int c = 0; c < int'(WIN); c++) begin
                bit hit8 = 1'b0;
                bit hit2 = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    if (bus8.led_en == ~(8'h01 << k)) begin
                        hit8     = 1'b1;
                        seen8[k] = 1'b1;
                        chk($sformatf("%s d8[%0d] seg", mon_e.tag, k), 32'(bus8.led_cx),
                            32'(exp_seg(mon_e.c8, k)));
                    end
                end
                for (int k = 0; k < 2; k++) begin
                    if (bus2.led_en == ~(2'b01 << k)) begin
                        hit2     = 1'b1;
                        seen2[k] = 1'b1;
                        chk($sformatf("%s d2[%0d] seg", mon_e.tag, k), 32'(bus2.led_cx),
                            32'(exp_seg(mon_e.c2, k)));
                    end
                end
                chk($sformatf("%s onehot", mon_e.tag), {30'd0, hit8, hit2}, 32'd3);
                if (c != int'(WIN) - 1) @(negedge clk);
            end
            chk($sformatf("%s scan8 cover", mon_e.tag), 32'(seen8), 32'hFF);
            chk($sformatf("%s scan2 cover", mon_e.tag), 32'(seen2), 32'h3);
            chk($sformatf("%s ovf8", mon_e.tag), 32'(bus8.overflow), 32'(mon_e.o8));
            chk($sformatf("%s ovf2", mon_e.tag), 32'(bus2.overflow), 32'(mon_e.o2));
            mon_busy = 1'b0;
        end
    end

    // Push the current model state and wait (bounded) for the monitor.
    task automatic expect_now(input string tag);
        exp_t e;
        bit   done = 1'b0;
        e.c8 = m_c8; e.c2 = m_c2; e.o8 = m_o8; e.o2 = m_o2; e.tag = tag;
        sb_q.push_back(e);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !mon_busy) begin
                done = 1'b1;
                break;
            end
        end
        chk({tag, " monitor done"}, 32'(done), 32'd1);
    endtask

    // Two-cycle-wide pulse on button and/or counter, then model update.
    task automatic pulse(input bit b, input bit c);
        @(negedge clk);
        b_in = b;
        c_in = c;
        repeat (2) @(negedge clk);
        b_in = 1'b0;
        c_in = 1'b0;
        repeat (3) @(negedge clk);
        if (c && m_run) begin
            m_c8 = (m_c8 + 1) % 100000000;
            m_c2 = (m_c2 + 1) % 100;
            if (m_c8 == 0) m_o8 = 1'b1;
            if (m_c2 == 0) m_o2 = 1'b1;
        end
        if (b) m_run = !m_run;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " en8"},  32'(bus8.led_en),   32'hFF);
        chk({tag, " cx8"},  32'(bus8.led_cx),   32'hFF);
        chk({tag, " ovf8"}, 32'(bus8.overflow), 32'd0);
        chk({tag, " en2"},  32'(bus2.led_en),   32'h3);
        chk({tag, " cx2"},  32'(bus2.led_cx),   32'hFF);
        chk({tag, " ovf2"}, 32'(bus2.overflow), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Scan order after release: digit (k-1)/SCAN lit on cycle k.
        rst = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            int d8;
            int d2;
            @(negedge clk);
            d8 = ((k - 1) / int'(SCAN)) % 8;
            d2 = ((k - 1) / int'(SCAN)) % 2;
            chk($sformatf("scan8 c%0d", k), 32'(bus8.led_en), 32'(8'(~(8'h01 << d8))));
            chk($sformatf("scan2 c%0d", k), 32'(bus2.led_en), 32'(2'(~(2'b01 << d2))));
            chk($sformatf("scan8 cx c%0d", k), 32'(bus8.led_cx), 32'(exp_seg(0, d8)));
        end
        expect_now("zero");

        pulse(1'b1, 1'b0);
        repeat (3) pulse(1'b0, 1'b1);
        expect_now("count3");

        pulse(1'b1, 1'b0);
        repeat (5) pulse(1'b0, 1'b1);
        expect_now("hold");
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        expect_now("resume");

        while (m_c8 < 10) pulse(1'b0, 1'b1);
        expect_now("carry10");
        while (m_c8 < 100) pulse(1'b0, 1'b1);
        expect_now("carry100_wrap2");
        repeat (5) pulse(1'b0, 1'b1);
        expect_now("ovf_sticky");

        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        expect_now("coinc_idle");
        pulse(1'b1, 1'b1);
        expect_now("coinc_run");
        pulse(1'b0, 1'b1);
        expect_now("after_coinc");

        for (int i = 0; i < 20; i++) begin
            pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            expect_now($sformatf("rand%0d", i));
        end

        if (!m_run) pulse(1'b1, 1'b0);
        repeat (3) pulse(1'b0, 1'b1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check_reset_outputs("midrun_reset");
        #32 rst = 1'b1;
        m_c8 = 0; m_c2 = 0; m_o8 = 1'b0; m_o2 = 1'b0; m_run = 1'b0;
        repeat (2) @(negedge clk);
        expect_now("after_reset");
        pulse(1'b0, 1'b1);
        expect_now("idle_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
